// File: rtl/key_pkg.sv
// Shared constants, key vector type and priority encoder for the key_filter block.
package key_pkg;

  localparam int unsigned KEY_W        = 32'd4;
  localparam int unsigned CNT_MAX_DEF  = 32'd999_999;
  localparam int unsigned LONG_MAX_DEF = 32'd49_999_999;

  typedef logic [KEY_W-1:0] key_vec_t;

  // Lowest set index wins; returns 0 for an empty vector.
  function automatic logic [1:0] key_prio_enc(input key_vec_t v);
    logic [1:0] code;
    code = 2'd0;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (v[i]) begin
        code = 2'(i);
      end else begin
        code = code;
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: 2-flop synchroniser, debounce filter, edge pulses and an
// optional hold counter built only when KEY_LONG_PRESS_EN is defined.
module key_filter_ch
  import key_pkg::*;
#(
  parameter int unsigned CNT_MAX  = CNT_MAX_DEF,
  parameter int unsigned LONG_MAX = LONG_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic i_key_n,
  output logic o_state,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_press_nxt
);

  localparam int unsigned CW = (CNT_MAX > 32'd0) ? $clog2(CNT_MAX + 32'd1) : 32'd1;
  localparam logic [CW-1:0] CNT_MAX_C = CNT_MAX[CW-1:0];

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stb;
  logic [CW-1:0] r_cnt;
  logic          r_state;
  logic          r_press;
  logic          r_release;

  logic          w_accept;
  logic          w_stb_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_press_nxt;
  logic          w_release_nxt;

  // Filter next state: a mismatch must persist CNT_MAX+1 edges; any match restarts.
  always_comb begin
    w_accept      = 1'b0;
    w_stb_nxt     = r_stb;
    w_cnt_nxt     = '0;
    if (r_sync2 == r_stb) begin
      w_cnt_nxt = '0;
    end else if (r_cnt == CNT_MAX_C) begin
      w_accept  = 1'b1;
      w_stb_nxt = r_sync2;
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
    w_press_nxt   = w_accept & ~r_sync2;
    w_release_nxt = w_accept &  r_sync2;
  end

  // Synchroniser, filter state and registered level/pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_stb     <= 1'b1;
      r_cnt     <= '0;
      r_state   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= i_key_n;
      r_sync2   <= r_sync1;
      r_stb     <= w_stb_nxt;
      r_cnt     <= w_cnt_nxt;
      r_state   <= ~w_stb_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  assign o_state     = r_state;
  assign o_press     = r_press;
  assign o_release   = r_release;
  assign o_press_nxt = w_press_nxt;

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned HW       = (LONG_MAX > 32'd0) ? $clog2(LONG_MAX + 32'd1) : 32'd1;
  localparam int unsigned LONG_PRE = LONG_MAX - 32'd1;
  localparam logic [HW-1:0] LONG_C     = LONG_MAX[HW-1:0];
  localparam logic [HW-1:0] LONG_PRE_C = LONG_PRE[HW-1:0];

  logic [HW-1:0] r_hcnt;
  logic          r_long;

  // Hold counter saturates at LONG_MAX, so the pulse fires once per hold.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_hcnt <= '0;
      r_long <= 1'b0;
    end else if (r_state) begin
      if (r_hcnt != LONG_C) begin
        r_hcnt <= r_hcnt + 1'b1;
      end else begin
        r_hcnt <= r_hcnt;
      end
      r_long <= (r_hcnt == LONG_PRE_C);
    end else begin
      r_hcnt <= '0;
      r_long <= 1'b0;
    end
  end

  assign o_long = r_long;
`else
  assign o_long = 1'b0;
`endif

endmodule

// File: rtl/key_filter.sv
// Four-key active-low debouncer with registered press priority encoder.
// Optional long-press detection is enabled by defining KEY_LONG_PRESS_EN.
module key_filter
  import key_pkg::*;
#(
  parameter int unsigned CNT_MAX  = CNT_MAX_DEF,
  parameter int unsigned LONG_MAX = LONG_MAX_DEF
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic             key_valid,
  output logic [1:0]       key_code,
  output logic [KEY_W-1:0] key_long
);

  key_vec_t   w_state;
  key_vec_t   w_press;
  key_vec_t   w_release;
  key_vec_t   w_long;
  key_vec_t   w_press_nxt;
  logic       r_valid;
  logic [1:0] r_code;

  for (genvar g = 0; g < KEY_W; g++) begin : g_ch
    key_filter_ch #(
      .CNT_MAX  (CNT_MAX),
      .LONG_MAX (LONG_MAX)
    ) u_ch (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .i_key_n     (key_in[g]),
      .o_state     (w_state[g]),
      .o_press     (w_press[g]),
      .o_release   (w_release[g]),
      .o_long      (w_long[g]),
      .o_press_nxt (w_press_nxt[g])
    );
  end

  // Encoder is fed from the channels' next-pulse terms so it lines up with key_press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_valid <= 1'b0;
      r_code  <= 2'd0;
    end else begin
      r_valid <= |w_press_nxt;
      r_code  <= key_prio_enc(w_press_nxt);
    end
  end

  assign key_state   = w_state;
  assign key_press   = w_press;
  assign key_release = w_release;
  assign key_long    = w_long;
  assign key_valid   = r_valid;
  assign key_code    = r_code;

endmodule
